// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: register map, STATUS bit
// positions and the transmit FSM state encoding.
package uart_pkg;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_DIV    = 4'h8;
  localparam logic [3:0] ADDR_IE     = 4'hC;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty
// are ignored, so callers may assert them unconditionally.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, programmable baud divisor,
// sticky overflow flag and a level interrupt when the transmitter drains.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int RESET_DIV  = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d, cnt_load;
  logic                 ie_q, ie_d, ovf_q, ovf_d, irq_q, irq_d;
  logic [31:0]          rdata_q, rdata_d, status;
  tx_state_t            state_q, state_d;
  logic                 txd_q, txd_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           sh_q, sh_d;

  logic                 wr_txdata, fifo_push, fifo_pop, ovf_set;
  logic                 fifo_full, fifo_empty, bit_end;
  logic [7:0]           fifo_dout;
  logic [CW-1:0]        fifo_count;
  logic                 unused_wdata;

  assign unused_wdata = ^wdata;

  assign wr_txdata = wr_en && (addr == ADDR_TXDATA);
  assign fifo_push = wr_txdata & ~fifo_full;
  assign ovf_set   = wr_txdata & fifo_full;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status                   = '0;
    status[ST_EMPTY]         = fifo_empty;
    status[ST_FULL]          = fifo_full;
    status[ST_BUSY]          = (state_q != TX_IDLE);
    status[ST_OVF]           = ovf_q;
    status[ST_CNT_LSB +: 8]  = 8'(fifo_count);
  end

  always_comb begin
    div_d   = div_q;
    ie_d    = ie_q;
    ovf_d   = ovf_q;
    rdata_d = rdata_q;
    if (wr_en) begin
      case (addr)
        ADDR_DIV:    div_d = wdata[DIV_WIDTH-1:0];
        ADDR_IE:     ie_d  = wdata[0];
        ADDR_STATUS: if (wdata[ST_OVF]) ovf_d = 1'b0;
        default:     ;
      endcase
    end
    // A drop in the same cycle as the W1C keeps the flag set.
    if (ovf_set) ovf_d = 1'b1;
    if (rd_en) begin
      case (addr)
        ADDR_STATUS: rdata_d = status;
        ADDR_DIV:    rdata_d = 32'(div_q);
        ADDR_IE:     rdata_d = {31'b0, ie_q};
        default:     rdata_d = '0;
      endcase
    end
    irq_d = ie_q & fifo_empty & (state_q == TX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= DIV_WIDTH'(RESET_DIV);
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  // The divisor is sampled only when a bit starts, so DIV writes never
  // stretch or shorten the bit in flight. Zero behaves as one.
  assign cnt_load = (div_q == '0) ? '0 : div_q - DIV_WIDTH'(1);
  assign bit_end  = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    txd_d    = txd_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = TX_START;
          txd_d    = 1'b0;
          cnt_d    = cnt_load;
          sh_d     = fifo_dout;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          txd_d   = sh_q[0];
          bit_d   = 3'd0;
          cnt_d   = cnt_load;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = cnt_load;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            txd_d = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = TX_START;
            txd_d    = 1'b0;
            cnt_d    = cnt_load;
            sh_d     = fifo_dout;
          end else begin
            state_d = TX_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      txd_q   <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  assign rdata = rdata_q;
  assign txd   = txd_q;
  assign irq   = irq_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, baud divisor width.
REQ-003 SHALL have parameter RESET_DIV, default 434, divisor after reset (50 MHz / 115200).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port wr_en  input  1  bus write strobe, one transfer per cycle.
REQ-007 SHALL have port rd_en  input  1  bus read strobe.
REQ-008 SHALL have port addr  input  4  byte offset within the UART window (UART_BASE decoded outside).
REQ-009 SHALL have port wdata  input  32  write data.
REQ-010 SHALL have port rdata  output  32  read data, registered.
REQ-011 SHALL have port txd  output  1  serial line, idle high.
REQ-012 SHALL have port irq  output  1  level interrupt to PLIC.

Function
REQ-013 SHALL map registers: 0x0 TXDATA (W), 0x4 STATUS (R/W1C), 0x8 DIV (R/W), 0xC IE (R/W); other offsets read 0, writes ignored.
REQ-014 SHALL push wdata[7:0] into the FIFO on a TXDATA write when not full; count updates at that edge.
REQ-015 SHALL drop a TXDATA write when full (full judged before any same-cycle pop) and set sticky STATUS.overflow.
REQ-016 SHALL define STATUS: bit0 empty, bit1 full, bit2 busy (FSM not IDLE), bit3 overflow; bits [15:8] FIFO count; rest 0.
REQ-017 SHALL clear overflow only on a STATUS write with wdata[3]=1; set wins over a simultaneous clear.
REQ-018 SHALL return read data on rdata one cycle after rd_en (same latency as brom); rdata holds otherwise.
REQ-019 SHALL treat a DIV value of 0 as 1; bit period = DIV clocks.
REQ-020 SHALL apply a DIV write at the next bit boundary, never mid-bit.
REQ-021 SHALL implement FSM IDLE -> START -> DATA -> STOP, 8N1 framing, LSB first.
REQ-022 SHALL in IDLE with FIFO non-empty pop one byte and enter START at that edge; txd goes low the same edge.
REQ-023 SHALL hold START low, each of 8 DATA bits, and STOP high for DIV clocks each; frame = 10*DIV clocks.
REQ-024 SHALL at STOP end go directly to START if FIFO non-empty (back-to-back, no idle cycle), else IDLE.
REQ-025 SHALL drive irq = IE[0] & empty & ~busy, registered.
REQ-026 SHALL never pop an empty FIFO; a push into an empty FIFO is visible to the FSM the next cycle.
REQ-027 SHALL allow push and pop in the same cycle when neither full nor empty; count unchanged.

Reset
REQ-028 SHALL on rst: FSM IDLE, FIFO empty, txd=1, rdata=0, irq=0, DIV=RESET_DIV, IE=0, overflow=0.
REQ-029 SHALL on rst mid-frame abort immediately; txd high at the first edge rst is sampled.

Structure
REQ-030 SHALL place register offsets, STATUS bit indices and tx_state_t enum in shared package uart_pkg.
REQ-031 SHALL instantiate one sub-module sync_fifo (parameterised depth/width, push/pop/full/empty/count).

Verification
REQ-032 SHALL test DIV=4, write 0x55 at edge 0 -> txd low at edge 2, bits 1,0,1,0,1,0,1,0 each 4 clocks, stop high, busy clears at edge 42.
REQ-033 SHALL test 9 back-to-back TXDATA writes with DIV=4 -> first pops, 8 fill FIFO, none dropped; 10th write sets overflow; W1C clears it.
REQ-034 SHALL test two bytes queued -> second start bit immediately follows first stop bit; 20*DIV clocks total low/high pattern checked.
REQ-035 SHALL test IE=1 with 0xA3 sent -> irq low while busy, high one cycle after STOP ends with FIFO empty.
REQ-036 SHALL test rst asserted mid-DATA -> txd=1, STATUS reads 0x00000001, DIV reads 434.
REQ-037 SHALL test DIV write 0 during frame -> current bit finishes at old period, later bits last 1 clock.
